axi_line_read_responder: RTL and testbench
==========================================

// Module: axi_line_read_responder
// PURPOSE
//  AXI4 read-channel responder (slave) backed by an internal word memory. Serves the AR/R
//  line-fill bursts issued by the instruction/data cache miss path (arlen=7, arsize=3,
//  arburst=WRAP). Used as the memory model in cache benches and as on-chip boot memory.
//  One outstanding burst at a time. A load port preloads or updates contents.
// PARAMETERS
//  addr_width        64    width of s_axi_araddr
//  data_width        64    R data width; beat = 8 bytes; only arsize=3 is supported
//  mem_words         4096  depth of backing memory in 64-bit words
//  first_beat_delay  2     idle cycles between AR handshake and first rvalid (0..15)
// PORTS
//  clock          in   1               rising-edge clock
//  reset          in   1               synchronous, active-high
//  s_axi_arvalid  in   1               read address valid
//  s_axi_arready  out  1               read address ready
//  s_axi_araddr   in   addr_width      byte address; bits [2:0] ignored
//  s_axi_arlen    in   8               beats-1
//  s_axi_arsize   in   3               bytes/beat log2
//  s_axi_arburst  in   2               0 FIXED, 1 INCR, 2 WRAP, 3 reserved
//  s_axi_rvalid   out  1               read data valid
//  s_axi_rready   in   1               read data ready
//  s_axi_rdata    out  data_width      read data
//  s_axi_rlast    out  1               last beat of burst
//  s_axi_rresp    out  2               0 OKAY, 2 SLVERR, 3 DECERR
//  load_enable    in   1               write load_data to memory this cycle
//  load_addr      in   $clog2(mem_words) word index
//  load_data      in   data_width      word to write
// BEHAVIOUR
//  - Reset: arready=0, rvalid=0, rlast=0, rdata=0, rresp=0, state IDLE, counters 0.
//    Memory contents NOT cleared. arready rises the first cycle after reset deasserts.
//  - All outputs registered. States: IDLE -> DELAY -> BURST -> IDLE.
//  - IDLE: arready=1. On arvalid&&arready (cycle T): capture word index araddr[3+:],
//    arlen, arsize, arburst; arready=0 from T+1; go DELAY (BURST if first_beat_delay=0).
//  - DELAY: count first_beat_delay cycles; first rvalid visible at T+1+first_beat_delay.
//  - BURST: beats = arlen+1. Beat held (rdata/rresp/rlast/rvalid stable) while
//    rvalid && !rready. On rvalid&&rready advance; next beat presented next cycle
//    (full throughput with rready held high). rlast=1 only on beat arlen.
//    After last handshake: rvalid=0, state IDLE, arready=1 next cycle (no same-cycle AR).
//  - Address sequence (word index w, start s): FIXED w=s every beat; INCR w=s+k;
//    WRAP: wrap size L=arlen+1 words, base=s&~(L-1), w=base+((s+k)&(L-1)).
//  - Errors (whole burst, rdata=0, beat count/rlast unchanged): arsize!=3 -> SLVERR;
//    arburst=3 -> SLVERR; WRAP with arlen not in {1,3,7,15} -> SLVERR.
//    Per beat: w >= mem_words -> DECERR, rdata=0 (other beats unaffected).
//  - INCR crossing mem_words: beats past end get DECERR; no wrap to 0.
//  - Load port active in every state; write visible to reads issued the next cycle.
//    A beat already presented (rvalid high) is not altered by a load to its word.
//  - Reset mid-burst: next cycle rvalid=0, burst abandoned, no rlast issued.
// TESTING
//  1 Preload w[i]=64'h1111_1111_1111_1111*i, i=0..15; AR 0x40 len7 size3 WRAP, rready=1
//    -> 8 beats w[8..15], rlast on beat 8, rresp=0, first rvalid at T+3.
//  2 AR 0x50 len7 WRAP -> data order w[10],w[11]..w[15],w[8],w[9]; rlast with w[9].
//  3 Test 1 with rready toggling 1,0,0,1,... -> data stable while stalled, 8 beats, none lost or repeated.
//  4 AR 0x40 len7 size2 WRAP -> 8 beats rresp=2'b10, rdata=0, rlast on beat 8.
//  5 AR addr=mem_words*8-16 len3 INCR -> rresp 0,0,3,3; rdata w[last-1],w[last],0,0.
//  6 Reset one cycle after 3rd beat accepted -> rvalid=0 next cycle; arready=1 the cycle
//    after reset deasserts; test 1 rerun returns correct data (memory retained).

Source files
------------

// File: rtl/axi_line_read_responder.sv
// axi_line_read_responder
//   AXI4 read-channel slave backed by an internal word memory. Serves one
//   burst at a time (FIXED / INCR / WRAP). It is intended for cache line fills
//   (arlen=7, arsize=3, WRAP). A side load port writes memory words in any state.
// Ports
//   clock, reset              rising-edge clock, synchronous active-high reset
//   s_axi_ar*                 read address channel (araddr[2:0] ignored)
//   s_axi_r*                  read data channel, all outputs registered
//   load_enable/addr/data     memory preload / update port (word indexed)
module axi_line_read_responder #(
  parameter int unsigned addr_width       = 64,
  parameter int unsigned data_width       = 64,
  parameter int unsigned mem_words        = 4096,
  parameter int unsigned first_beat_delay = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  input  logic [addr_width-1:0]        s_axi_araddr,
  input  logic [7:0]                   s_axi_arlen,
  input  logic [2:0]                   s_axi_arsize,
  input  logic [1:0]                   s_axi_arburst,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  output logic [data_width-1:0]        s_axi_rdata,
  output logic                         s_axi_rlast,
  output logic [1:0]                   s_axi_rresp,
  input  logic                         load_enable,
  input  logic [$clog2(mem_words)-1:0] load_addr,
  input  logic [data_width-1:0]        load_data
);

  localparam int unsigned IDXW = $clog2(mem_words);
  localparam int unsigned WW   = addr_width - 3;
  localparam logic [3:0]  DLY  = 4'(first_beat_delay);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_BURST} state_t;

  state_t                state_q;
  logic [data_width-1:0] mem [mem_words];

  logic                  arready_q, rvalid_q, rlast_q;
  logic [data_width-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic [WW-1:0]         start_q;
  logic [7:0]            len_q, beat_q;
  logic [1:0]            burst_q;
  logic                  err_q;
  logic [3:0]            dly_q;

  logic                  unused_addr_lsbs;
  assign unused_addr_lsbs = ^s_axi_araddr[2:0];

  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

  always_ff @(posedge clock) begin
    if (load_enable) mem[load_addr] <= load_data;
  end

  logic            ar_hs, last_hs, present;
  logic            req_err, src_err;
  logic [WW-1:0]   src_start;
  logic [7:0]      src_len, src_beat;
  logic [1:0]      src_burst;
  logic [WW:0]     start_x, beat_x, mask_x, beat_w;
  logic            in_range;
  logic [IDXW-1:0] beat_idx;

  // The beat to present next is computed from the live AR inputs when it is
  // the first beat presented straight out of IDLE, otherwise from the
  // captured burst.
  always_comb begin
    ar_hs   = (state_q == S_IDLE) && s_axi_arvalid && arready_q;
    last_hs = (state_q == S_BURST) && rvalid_q && s_axi_rready && rlast_q;
    present = (ar_hs && (DLY == 4'd0)) ||
              ((state_q == S_DELAY) && (dly_q == 4'd0)) ||
              ((state_q == S_BURST) && rvalid_q && s_axi_rready && !rlast_q);

    req_err = (s_axi_arsize != 3'd3) || (s_axi_arburst == 2'd3) ||
              ((s_axi_arburst == 2'd2) &&
               !(s_axi_arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));

    if (state_q == S_IDLE) begin
      src_start = s_axi_araddr[addr_width-1:3];
      src_len   = s_axi_arlen;
      src_burst = s_axi_arburst;
      src_err   = req_err;
    end else begin
      src_start = start_q;
      src_len   = len_q;
      src_burst = burst_q;
      src_err   = err_q;
    end
    src_beat = (state_q == S_BURST) ? beat_q + 8'd1 : 8'd0;

    // One extra bit keeps INCR overflow past mem_words from wrapping to 0.
    start_x = {1'b0, src_start};
    beat_x  = {{(WW+1-8){1'b0}}, src_beat};
    mask_x  = {{(WW+1-8){1'b0}}, src_len};
    case (src_burst)
      2'd0:    beat_w = start_x;
      2'd2:    beat_w = (start_x & ~mask_x) | ((start_x + beat_x) & mask_x);
      default: beat_w = start_x + beat_x;
    endcase
    in_range = beat_w < (WW+1)'(mem_words);
    beat_idx = beat_w[IDXW-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      start_q   <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      burst_q   <= '0;
      err_q     <= 1'b0;
      dly_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            arready_q <= 1'b0;
            start_q   <= s_axi_araddr[addr_width-1:3];
            len_q     <= s_axi_arlen;
            burst_q   <= s_axi_arburst;
            err_q     <= req_err;
            if (DLY == 4'd0) begin
              state_q <= S_BURST;
            end else begin
              state_q <= S_DELAY;
              dly_q   <= DLY - 4'd1;
            end
          end
        end
        S_DELAY: begin
          if (dly_q == 4'd0) state_q <= S_BURST;
          else               dly_q   <= dly_q - 4'd1;
        end
        S_BURST: begin
          if (last_hs) begin
            state_q   <= S_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Load the output registers with the next beat; while stalled nothing
      // here fires, so the presented beat stays frozen.
      if (present) begin
        rvalid_q <= 1'b1;
        rlast_q  <= (src_beat == src_len);
        beat_q   <= src_beat;
        if (src_err) begin
          rresp_q <= 2'd2;
          rdata_q <= '0;
        end else if (!in_range) begin
          rresp_q <= 2'd3;
          rdata_q <= '0;
        end else begin
          rresp_q <= 2'd0;
          rdata_q <= mem[beat_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_line_read_responder.sv
module tb_axi_line_read_responder;
  localparam int MW  = 4096;
  localparam int DLY = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [63:0] s_axi_araddr = '0;
  logic [7:0]  s_axi_arlen = '0;
  logic [2:0]  s_axi_arsize = '0;
  logic [1:0]  s_axi_arburst = '0;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic [63:0] s_axi_rdata;
  logic        s_axi_rlast;
  logic [1:0]  s_axi_rresp;
  logic        load_enable = 1'b0;
  logic [11:0] load_addr = '0;
  logic [63:0] load_data = '0;

  always #5 clock = ~clock;

  axi_line_read_responder #(
    .addr_width(64), .data_width(64), .mem_words(MW), .first_beat_delay(DLY)
  ) dut (
    .clock(clock), .reset(reset),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rlast(s_axi_rlast), .s_axi_rresp(s_axi_rresp),
    .load_enable(load_enable), .load_addr(load_addr), .load_data(load_data)
  );

  int total = 0;
  int bad   = 0;

  logic [63:0]     model_mem [MW];
  logic [63:0]     e_data[$];
  logic [1:0]      e_resp[$];
  longint unsigned e_word[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got=timeout want=completion at %0t", nm, $time);
  endtask

  // Expected beats straight from the burst rules, using modulo arithmetic.
  function automatic void build(input logic [63:0] addr, input int len, input int size,
                                input int burst);
    bit err;
    longint unsigned s, w, L;
    e_data.delete(); e_resp.delete(); e_word.delete();
    err = (size != 3) || (burst == 3) ||
          (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    s = addr >> 3;
    L = longint'(len) + 1;
    for (int k = 0; k <= len; k++) begin
      if (burst == 0)      w = s;
      else if (burst == 2) w = s - (s % L) + ((s + longint'(k)) % L);
      else                 w = s + longint'(k);
      e_word.push_back(w);
      if (err) begin
        e_data.push_back(64'd0); e_resp.push_back(2'd2);
      end else if (w >= longint'(MW)) begin
        e_data.push_back(64'd0); e_resp.push_back(2'd3);
      end else begin
        e_data.push_back(model_mem[w]); e_resp.push_back(2'd0);
      end
    end
  endfunction

  // Called and returns at a negedge. rmode: 0 rready=1, 1 pattern 1,0,0, 2 random.
  task automatic run_txn(input logic [63:0] addr, input int len, input int size,
                         input int burst, input int rmode, input bit poke,
                         output int got, output logic [1:0] r0, output logic [1:0] rl);
    int lat, waitc;
    bit stalled, poked, seen;
    bit rr;
    logic [63:0] hd;
    logic [1:0]  hr;
    logic        hl;
    build(addr, len, size, burst);
    got = 0; r0 = 2'd0; rl = 2'd0; poked = 0; stalled = 0; seen = 0;
    hd = '0; hr = '0; hl = 1'b0;
    s_axi_arvalid = 1'b1;
    s_axi_araddr  = addr;
    s_axi_arlen   = 8'(len);
    s_axi_arsize  = 3'(size);
    s_axi_arburst = 2'(burst);
    waitc = 0;
    while (!s_axi_arready && waitc < 20) begin
      @(negedge clock);
      waitc++;
    end
    if (!s_axi_arready) begin
      s_axi_arvalid = 1'b0;
      timeout("ar_handshake");
      return;
    end
    @(negedge clock);
    s_axi_arvalid = 1'b0;
    chk("arready_low_after_ar", s_axi_arready, 1'b0);
    lat = 1;
    while (got <= len && lat < 400) begin
      if (stalled) begin
        chk("hold_rvalid", s_axi_rvalid, 1'b1);
        chk("hold_rdata", s_axi_rdata, hd);
        chk("hold_rresp", s_axi_rresp, hr);
        chk("hold_rlast", s_axi_rlast, hl);
      end
      case (rmode)
        0:       rr = 1'b1;
        1:       rr = (lat % 3) == 0;
        default: rr = 1'($urandom_range(0, 1));
      endcase
      s_axi_rready = rr;
      load_enable  = 1'b0;
      if (s_axi_rvalid) begin
        if (!seen) begin
          seen = 1;
          chk("first_rvalid_latency", 64'(lat), 64'(1 + DLY));
        end
        if (rr) begin
          chk("beat_rdata", s_axi_rdata, e_data[got]);
          chk("beat_rresp", s_axi_rresp, e_resp[got]);
          chk("beat_rlast", s_axi_rlast, (got == len));
          if (got == 0) r0 = s_axi_rresp;
          rl = s_axi_rresp;
          got++;
          stalled = 0;
        end else begin
          stalled = 1;
          hd = s_axi_rdata; hr = s_axi_rresp; hl = s_axi_rlast;
          if (poke && !poked && e_resp[got] == 2'd0) begin
            poked       = 1;
            load_enable = 1'b1;
            load_addr   = 12'(e_word[got]);
            load_data   = ~hd;
            model_mem[e_word[got]] = ~hd;
          end
        end
      end
      @(negedge clock);
      lat++;
    end
    s_axi_rready = 1'b0;
    load_enable  = 1'b0;
    if (got <= len) begin
      timeout("r_burst");
    end else begin
      chk("rvalid_low_after_last", s_axi_rvalid, 1'b0);
      chk("arready_high_after_last", s_axi_arready, 1'b1);
    end
  endtask

  typedef struct {
    logic [63:0] addr;
    int          len;
    int          size;
    int          burst;
    int          rmode;
    bit          poke;
    int          beats;
    logic [1:0]  resp_first;
    logic [1:0]  resp_last;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int got, acc, waitc;
    logic [1:0] r0, rl;
    longint unsigned w;

    tbl[0] = '{64'h40,   7, 3, 2, 0, 0, 8, 2'd0, 2'd0};
    tbl[1] = '{64'h50,   7, 3, 2, 0, 0, 8, 2'd0, 2'd0};
    tbl[2] = '{64'h40,   7, 3, 2, 1, 1, 8, 2'd0, 2'd0};
    tbl[3] = '{64'h40,   7, 2, 2, 0, 0, 8, 2'd2, 2'd2};
    tbl[4] = '{64'h7FF0, 3, 3, 1, 0, 0, 4, 2'd0, 2'd3};
    tbl[5] = '{64'h40,   7, 3, 3, 2, 0, 8, 2'd2, 2'd2};
    tbl[6] = '{64'h48,   5, 3, 2, 0, 0, 6, 2'd2, 2'd2};
    tbl[7] = '{64'h18,   3, 3, 0, 2, 0, 4, 2'd0, 2'd0};
    tbl[8] = '{64'h7FF8, 0, 3, 1, 0, 0, 1, 2'd0, 2'd0};
    tbl[9] = '{64'h8000, 1, 3, 1, 0, 0, 2, 2'd3, 2'd3};

    // Reset state and preload through the load port (active during reset).
    repeat (3) @(negedge clock);
    chk("reset_arready", s_axi_arready, 1'b0);
    chk("reset_rvalid", s_axi_rvalid, 1'b0);
    chk("reset_rlast", s_axi_rlast, 1'b0);
    chk("reset_rdata", s_axi_rdata, 64'd0);
    chk("reset_rresp", s_axi_rresp, 2'd0);
    for (int i = 0; i < MW; i++) begin
      load_enable = 1'b1;
      load_addr   = 12'(i);
      load_data   = (i < 16) ? 64'h1111_1111_1111_1111 * 64'(i) : {$urandom, $urandom};
      model_mem[i] = load_data;
      @(negedge clock);
    end
    load_enable = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    chk("arready_after_reset", s_axi_arready, 1'b1);

    foreach (tbl[i]) begin
      run_txn(tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].burst, tbl[i].rmode,
              tbl[i].poke, got, r0, rl);
      chk($sformatf("tbl%0d_beats", i), 64'(got), 64'(tbl[i].beats));
      chk($sformatf("tbl%0d_resp_first", i), r0, tbl[i].resp_first);
      chk($sformatf("tbl%0d_resp_last", i), rl, tbl[i].resp_last);
    end

    // Reset one cycle after the third beat is accepted.
    s_axi_arvalid = 1'b1; s_axi_araddr = 64'h40; s_axi_arlen = 8'd7;
    s_axi_arsize = 3'd3; s_axi_arburst = 2'd2;
    waitc = 0;
    while (!s_axi_arready && waitc < 20) begin @(negedge clock); waitc++; end
    if (!s_axi_arready) timeout("rst_ar_handshake");
    @(negedge clock);
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b1;
    acc = 0;
    waitc = 0;
    while (acc < 3 && waitc < 50) begin
      if (s_axi_rvalid) acc++;
      @(negedge clock);
      waitc++;
    end
    if (acc < 3) timeout("rst_three_beats");
    reset = 1'b1;
    s_axi_rready = 1'b0;
    @(negedge clock);
    chk("midburst_reset_rvalid", s_axi_rvalid, 1'b0);
    chk("midburst_reset_rlast", s_axi_rlast, 1'b0);
    chk("midburst_reset_arready", s_axi_arready, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    chk("midburst_arready_after_reset", s_axi_arready, 1'b1);
    chk("midburst_rvalid_after_reset", s_axi_rvalid, 1'b0);
    run_txn(64'h40, 7, 3, 2, 0, 0, got, r0, rl);
    chk("rerun_beats", 64'(got), 64'd8);

    // Randomized bursts and loads against the model.
    for (int t = 0; t < 40; t++) begin
      int sel, len, size, burst;
      logic [63:0] addr;
      for (int j = 0; j < 2; j++) begin
        load_enable = 1'b1;
        load_addr   = 12'($urandom_range(0, MW - 1));
        load_data   = {$urandom, $urandom};
        model_mem[load_addr] = load_data;
        @(negedge clock);
      end
      load_enable = 1'b0;
      sel = $urandom_range(0, 9);
      if (sel < 6)      w = longint'($urandom_range(0, MW - 1));
      else if (sel < 9) w = longint'($urandom_range(MW - 16, MW - 1));
      else              w = {$urandom, $urandom} >> 3;
      addr = (64'(w) << 3) | 64'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: len = 0;
        1: len = 1;
        2: len = 3;
        3: len = 7;
        4: len = 15;
        default: len = $urandom_range(0, 20);
      endcase
      size  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : 3;
      burst = $urandom_range(0, 3);
      run_txn(addr, len, size, burst, 2, 0, got, r0, rl);
      chk("rand_beats", 64'(got), 64'(len + 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    total++;
    bad++;
    $display("FAIL watchdog: got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
